booth_radix4_mult: RTL
======================

BOOTH_RADIX4_MULT -- requirements
Module: booth_radix4_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and at least 4.
REQ-002 SHALL have localparam ITER, equal to WIDTH/2+1: the number of radix-4 iterations per operation.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled at the rising edge of clk.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 = both operands two's complement; 0 = both unsigned; sampled with start.
REQ-007 SHALL have port multiplicand, input, WIDTH bits: operand M, sampled with start.
REQ-008 SHALL have port multiplier, input, WIDTH bits: operand Q, sampled with start.
REQ-009 SHALL have port product, output, 2*WIDTH bits: the result, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-012 SHALL have port iter_count, output, clog2(ITER+1) bits: the remaining iteration count, for debug.

Function
REQ-013 SHALL implement three states, IDLE, RUN and DONE; reset enters IDLE.
REQ-014 SHALL accept start=1 only in IDLE or DONE; on acceptance it SHALL capture the operands and mode, clear the accumulator, clear Q_1, set iter_count=ITER and enter RUN.
REQ-015 SHALL ignore start, operand and mode changes while in RUN; the captured values SHALL NOT change.
REQ-016 SHALL extend each operand internally to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when 0.
REQ-017 SHALL, in each RUN cycle, recode the triplet {Q[1],Q[0],Q_1}:
- 000 or 111: add 0
- 001 or 010: add +M
- 011: add +2M
- 100: add -2M
- 101 or 110: add -M
REQ-018 SHALL then arithmetic-shift right by 2 the combined {A,Q,Q_1} and decrement iter_count in the same cycle.
REQ-019 SHALL size the accumulator so that ±2M never overflows, i.e. at least WIDTH+3 bits.
REQ-020 SHALL, on the edge where iter_count reaches 0, load product with the low 2*WIDTH bits of {A,Q} and enter DONE.
REQ-021 SHALL make product exact for all operand pairs in both modes, including the most-negative × most-negative signed case and the all-ones × all-ones unsigned case.
REQ-022 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE; DONE SHALL last one cycle.
REQ-023 SHALL meet this latency: with start accepted at edge t, busy is high after edges t..t+ITER-1, and done is high after edge t+ITER (ITER+1 cycles from start to done).
REQ-024 SHALL, in DONE with start=1, accept the new operation (back-to-back) and go to RUN; otherwise it SHALL go to IDLE.
REQ-025 SHALL hold product stable from DONE until the next result is loaded; product SHALL NOT change during RUN.
REQ-026 SHALL hold iter_count at 0 in IDLE and DONE.

Reset
REQ-027 SHALL, while reset_n=0, immediately force state=IDLE, product=0, busy=0, done=0, iter_count=0, and clear the accumulator, Q and Q_1, independent of clk.
REQ-028 SHALL, if reset is asserted mid-operation, abandon the operation with no done pulse.
REQ-029 SHALL, after reset_n rises, accept start on the first rising edge of clk.

Verification
REQ-030 SHALL cover: WIDTH=8, signed_mode=1, M=-128, Q=-128 -> product=16'h4000; done exactly 5 cycles after the start edge.
REQ-031 SHALL cover: WIDTH=8, signed_mode=0, M=255, Q=255 -> product=16'hFE01; the same input bits with signed_mode=1 -> product=16'h0001.
REQ-032 SHALL cover: WIDTH=8 signed, M=-7, Q=3 -> product=16'hFFEB; then start held high in DONE with M=5, Q=6 -> product=16'h001E with no idle cycle between the two operations.
REQ-033 SHALL cover: start pulsed during RUN with different operands -> ignored; the first result is intact; only one done pulse.
REQ-034 SHALL cover: reset_n pulled low at iteration 2 of an operation -> outputs zeroed asynchronously; no done pulse; the next operation is correct.
REQ-035 SHALL cover: WIDTH=4 signed, M=7, Q=-8 -> product=8'hC8; plus an exhaustive sweep of all 256 pairs in each mode against a reference model.

Source files
------------

// File: rtl/booth_radix4_mult_if.sv
// booth_radix4_mult_if: operand/result bundle for the radix-4 Booth multiplier.
//   start        : operation request, sampled on the rising clock edge
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   multiplicand : operand M (WIDTH bits)
//   multiplier   : operand Q (WIDTH bits)
//   product      : registered result (2*WIDTH bits)
//   busy         : high while an operation is iterating
//   done         : one-cycle pulse marking a fresh product
//   iter_count   : remaining iterations (debug)
interface booth_radix4_mult_if #(
    parameter int WIDTH = 8
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;
    logic [CW-1:0]        iter_count;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product, busy, done, iter_count
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product, busy, done, iter_count
    );
endinterface

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier, one recoded digit
// per clock, signed or unsigned operands selected per operation.
//   clk     : clock, rising-edge active
//   reset_n : asynchronous active-low reset
//   bus     : booth_radix4_mult_if slave (start/mode/operands in,
//             product/busy/done/iter_count out)
// Operands are extended to WIDTH+2 bits so that an unsigned operand looks
// like a non-negative signed one; WIDTH/2+1 digits then cover the whole
// extended multiplier and {A,Q} holds the exact signed product.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset_n,
    booth_radix4_mult_if.slave bus
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int EW   = WIDTH + 2;        // extended operand width
    localparam int AW   = WIDTH + 3;        // accumulator width, holds +/-2M
    localparam int TW   = AW + EW + 1;      // {A,Q,Q_1}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [EW-1:0]      q_q, q_d;
    logic               q1_q, q1_d;
    logic [EW-1:0]      m_q, m_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CW-1:0]      iter_q, iter_d;

    logic [EW-1:0]      m_ext, q_ext;
    logic [AW-1:0]      m_aw, pp, sum;
    logic [TW-1:0]      shifted;

    // Datapath: operand extension, digit recoding, add and 2-bit arithmetic shift.
    always_comb begin
        if (bus.signed_mode) begin
            m_ext = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            q_ext = {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier};
        end else begin
            m_ext = {2'b00, bus.multiplicand};
            q_ext = {2'b00, bus.multiplier};
        end

        m_aw = {{(AW-EW){m_q[EW-1]}}, m_q};

        pp = '0;
        case ({q_q[1:0], q1_q})
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = m_aw;
            3'b011:         pp = m_aw << 1;
            3'b100:         pp = -(m_aw << 1);
            3'b101, 3'b110: pp = -m_aw;
        endcase

        sum = a_q + pp;
        // {sum,Q,Q_1} >>> 2: the two bits dropped are Q[0] and the old Q_1,
        // the new Q_1 is the old Q[1].
        shifted = {{2{sum[AW-1]}}, sum, q_q[EW-1:1]};
    end

    // Control: next-state and register loads.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        product_d = product_q;
        iter_d    = iter_q;

        case (state_q)
            IDLE, DONE: begin
                iter_d  = '0;
                state_d = IDLE;
                if (bus.start) begin
                    m_d     = m_ext;
                    q_d     = q_ext;
                    q1_d    = 1'b0;
                    a_d     = '0;
                    iter_d  = ITER[CW-1:0];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = shifted[TW-1:EW+1];
                q_d    = shifted[EW:1];
                q1_d   = shifted[0];
                iter_d = iter_q - CW'(1);
                if (iter_q == CW'(1)) begin
                    product_d = shifted[2*WIDTH:1];
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                iter_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            product_q <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            product_q <= product_d;
            iter_q    <= iter_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.product    = product_q;
    assign bus.iter_count = iter_q;
endmodule
